// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the burst RAM slave.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Beat address sequencer: next address for FIXED/INCR/WRAP, word index into
// the RAM, burst-level legality and per-beat range check.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [7:0]                   len,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  output logic [ADDR_WIDTH-1:0]        next_addr,
  output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
  output logic                         burst_err,
  output logic                         beat_err
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG  = $clog2(BYTES);
  localparam int IDX_WIDTH = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
  localparam logic [2:0]            LEGAL_SIZE = 3'(SIZE_LOG);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH:0]   offset;
  logic                  wrap_len_ok;
  logic                  unused_offset;

  // Next beat address; WRAP stays inside a (len+1)*2^size aligned block
  always_comb begin
    step      = ONE << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    aligned   = addr & ~(step - ONE);
    case (burst)
      BURST_INCR: next_addr = aligned + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

  // Burst legality and per-beat window check relative to BASE_ADDR
  always_comb begin
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_err   = (size != LEGAL_SIZE) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);
    offset      = {1'b0, addr} - {1'b0, BASE_ADDR};
    beat_err    = (addr < BASE_ADDR) || (offset >= MEM_BYTES);
    word_idx    = offset[SIZE_LOG +: IDX_WIDTH];
  end

  assign unused_offset = ^offset;

endmodule

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 burst RAM slave: independent write and read FSMs around a
// byte-strobed synchronous RAM, with per-beat SLVERR signalling.
module axi4_burst_ram_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_burst_err;
  logic                  w_beat_err;
  logic                  w_fire;
  logic                  w_last_beat;
  logic                  w_beat_bad;

  r_state_t              r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_burst_err;
  logic                  r_beat_err;
  logic                  r_ok;

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_w_addr_gen (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next_addr),
    .word_idx  (w_idx),
    .burst_err (w_burst_err),
    .beat_err  (w_beat_err)
  );

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_r_addr_gen (
    .addr      (r_addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next_addr),
    .word_idx  (r_idx),
    .burst_err (r_burst_err),
    .beat_err  (r_beat_err)
  );

  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_bad  = w_burst_err || w_beat_err || (s_axi_wlast != w_last_beat);
  assign r_ok        = !r_burst_err && !r_beat_err;

  // Strobed RAM write; contents survive reset and errored beats are dropped
  always_ff @(posedge aclk) begin
    if (w_fire && !w_burst_err && !w_beat_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: AW accept, beat-counted W phase, then a single B response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_next_addr;
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err || w_beat_bad;
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: AR accept, one-cycle RAM fetch per beat, hold beat until R handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_id          <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_FETCH;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_FETCH: begin
          s_axi_rdata  <= r_ok ? mem[r_idx] : '0;
          s_axi_rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
          s_axi_rid    <= r_id;
          s_axi_rlast  <= (r_cnt == r_len);
          s_axi_rvalid <= 1'b1;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            if (s_axi_rlast) begin
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr  <= r_next_addr;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Self-checking bench for axi4_burst_ram_slave against a byte-array model.
module tb_axi4_burst_ram_slave;

  localparam int          MEM_BYTES = 4096;
  localparam logic [31:0] BASE      = 32'h0;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] wdata_q [256];
  logic [3:0]  wstrb_q [256];

  axi4_burst_ram_slave dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  // Free-running clock
  always #5 aclk = ~aclk;

  // Hard stop in case a handshake never completes
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value with the bench's expectation
  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    assert (observed === expected) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit burst_ok(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size != 3'd2) return 1'b0;
    if (burst == 2'b11) return 1'b0;
    if (burst == 2'b10) return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return 1'b1;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < MEM_BYTES);
  endfunction

  // Byte address of beat i, from the burst rules in plain arithmetic
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    int unsigned blk;
    int unsigned base;
    if (burst == 2'b01) return (i == 0) ? start : ((start / 4) * 4 + 4 * i);
    if (burst == 2'b10) begin
      blk  = (int'(len) + 1) * 4;
      base = start - (start % blk);
      return base + ((start - base + 4 * i) % blk);
    end
    return start;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) & 32'hFFFF_FFFC;
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  // Full write burst: AW, W beats from wdata_q/wstrb_q, then B with optional bready stalls
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input bit early_last, input bit stall);
    bit          ok_all;
    bit          bad;
    bit          done;
    bit          prev_stall;
    logic [31:0] a;
    logic [31:0] w;
    int          n;
    ok_all = burst_ok(len, size, burst);
    bad    = !ok_all || early_last;
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 200) begin @(negedge aclk); n++; end
    check_output("aw_accept", {63'd0, s_axi_awready}, 64'd1);
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (stall) while ($urandom_range(0, 2) == 0) @(negedge aclk);
      s_axi_wdata  = wdata_q[i];
      s_axi_wstrb  = wstrb_q[i];
      s_axi_wlast  = early_last ? (i == 0) : (i == int'(len));
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) check_output("w_accept", {63'd0, s_axi_wready}, 64'd1);
      @(negedge aclk);
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      a = beat_addr(addr, len, burst, i);
      if (!in_range(a)) bad = 1'b1;
      else if (ok_all) begin
        w = (a - BASE) & 32'hFFFF_FFFC;
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[i][b]) ref_mem[w + b] = wdata_q[i][b*8 +: 8];
        end
      end
    end
    done = 1'b0;
    prev_stall = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      if (prev_stall) check_output("b_hold_valid", {63'd0, s_axi_bvalid}, 64'd1);
      s_axi_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = 1'b0;
      if (s_axi_bvalid) begin
        check_output("bid", {60'd0, s_axi_bid}, {60'd0, id});
        check_output("bresp", {62'd0, s_axi_bresp}, bad ? 64'd2 : 64'd0);
        if (s_axi_bready) done = 1'b1;
        else prev_stall = 1'b1;
      end
      @(negedge aclk);
      n++;
    end
    s_axi_bready = 1'b0;
    check_output("b_handshake", {63'd0, done}, 64'd1);
    check_output("b_single", {63'd0, s_axi_bvalid}, 64'd0);
  endtask

  // Full read burst with optional rready stalls; every presented beat is checked
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall);
    bit          ok_all;
    bit          ok;
    bit          prev_stall;
    logic [31:0] a;
    logic [31:0] exp_data;
    int          n;
    int          lat;
    int          beat;
    ok_all = burst_ok(len, size, burst);
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 200) begin @(negedge aclk); n++; end
    check_output("ar_accept", {63'd0, s_axi_arready}, 64'd1);
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!s_axi_rvalid && lat < 10) begin @(negedge aclk); lat++; end
    check_output("r_first_latency", 64'(lat), 64'd2);
    beat = 0;
    n = 0;
    prev_stall = 1'b0;
    while (beat <= int'(len) && n < 3000) begin
      if (prev_stall) check_output("r_hold_valid", {63'd0, s_axi_rvalid}, 64'd1);
      s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = 1'b0;
      if (s_axi_rvalid) begin
        a        = beat_addr(addr, len, burst, beat);
        ok       = ok_all && in_range(a);
        exp_data = ok ? ref_word(a) : 32'h0;
        check_output("rid", {60'd0, s_axi_rid}, {60'd0, id});
        check_output("rresp", {62'd0, s_axi_rresp}, ok ? 64'd0 : 64'd2);
        check_output("rdata", {32'd0, s_axi_rdata}, {32'd0, exp_data});
        check_output("rlast", {63'd0, s_axi_rlast}, (beat == int'(len)) ? 64'd1 : 64'd0);
        if (s_axi_rready) beat++;
        else prev_stall = 1'b1;
      end
      @(negedge aclk);
      n++;
    end
    s_axi_rready = 1'b0;
    check_output("r_beat_count", 64'(beat), 64'(int'(len) + 1));
    check_output("r_no_extra", {63'd0, s_axi_rvalid}, 64'd0);
  endtask

  // Directed sequence with randomized data, addresses and stalls
  initial begin
    logic [31:0] addr;
    int          n;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    repeat (3) @(negedge aclk);
    check_output("rst_awready", {63'd0, s_axi_awready}, 64'd0);
    check_output("rst_wready",  {63'd0, s_axi_wready},  64'd0);
    check_output("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
    check_output("rst_arready", {63'd0, s_axi_arready}, 64'd0);
    check_output("rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    check_output("rst_bid",     {60'd0, s_axi_bid},     64'd0);
    check_output("rst_bresp",   {62'd0, s_axi_bresp},   64'd0);
    check_output("rst_rid",     {60'd0, s_axi_rid},     64'd0);
    check_output("rst_rresp",   {62'd0, s_axi_rresp},   64'd0);
    check_output("rst_rdata",   {32'd0, s_axi_rdata},   64'd0);
    check_output("rst_rlast",   {63'd0, s_axi_rlast},   64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_output("post_rst_awready", {63'd0, s_axi_awready}, 64'd1);
    check_output("post_rst_arready", {63'd0, s_axi_arready}, 64'd1);
    check_output("post_rst_wready",  {63'd0, s_axi_wready},  64'd0);

    $display("[TB] seeding memory");
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wdata_q[i] = $urandom;
        wstrb_q[i] = 4'hF;
      end
      write_burst(4'(blk), 32'(blk * 1024), 8'd255, 3'd2, 2'b01, 1'b0, 1'b0);
    end

    $display("[TB] single beat write and read");
    wdata_q[0] = 32'hDEAD_BEEF; wstrb_q[0] = 4'hF;
    write_burst(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);
    read_burst(4'h3, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("[TB] partial strobe merge");
    wdata_q[0] = 32'hFFFF_FFFF; wstrb_q[0] = 4'hF;
    write_burst(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);
    wdata_q[0] = 32'h1122_3344; wstrb_q[0] = 4'h3;
    write_burst(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);
    read_burst(4'h2, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("[TB] INCR write then WRAP read");
    for (int i = 0; i < 4; i++) begin
      wdata_q[i] = 32'hA000_0000 + 32'(i);
      wstrb_q[i] = 4'hF;
    end
    write_burst(4'h7, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0);
    read_burst(4'h8, 32'h108, 8'd3, 3'd2, 2'b10, 1'b0);

    $display("[TB] out-of-range accesses");
    wdata_q[0] = 32'h5555_5555; wstrb_q[0] = 4'hF;
    write_burst(4'h9, BASE + 32'd4096, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);
    read_burst(4'h1, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    read_burst(4'h2, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0);

    $display("[TB] FIXED burst with mixed strobes");
    for (int i = 0; i < 4; i++) begin
      wdata_q[i] = $urandom;
      wstrb_q[i] = 4'($urandom_range(0, 15));
    end
    write_burst(4'h4, 32'h200, 8'd3, 3'd2, 2'b00, 1'b0, 1'b1);
    read_burst(4'h4, 32'h200, 8'd2, 3'd2, 2'b00, 1'b1);

    $display("[TB] illegal bursts");
    wdata_q[0] = 32'h0BAD_0BAD; wdata_q[1] = 32'h0BAD_0BAD;
    wstrb_q[0] = 4'hF; wstrb_q[1] = 4'hF;
    write_burst(4'hA, 32'h300, 8'd1, 3'd2, 2'b11, 1'b0, 1'b0);
    write_burst(4'hC, 32'h304, 8'd0, 3'd1, 2'b01, 1'b0, 1'b0);
    read_burst(4'hB, 32'h300, 8'd1, 3'd2, 2'b11, 1'b0);
    read_burst(4'hD, 32'h300, 8'd2, 3'd2, 2'b10, 1'b0);
    read_burst(4'hD, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);

    $display("[TB] random len15 bursts with stalls");
    for (int k = 0; k < 6; k++) begin
      addr = 32'($urandom_range(0, (MEM_BYTES - 64) / 4)) * 32'd4;
      for (int i = 0; i < 16; i++) begin
        wdata_q[i] = $urandom;
        wstrb_q[i] = 4'($urandom_range(0, 15));
      end
      write_burst(4'($urandom_range(0, 15)), addr, 8'd15, 3'd2, 2'b01, 1'b0, 1'b1);
      read_burst(4'($urandom_range(0, 15)), addr, 8'd15, 3'd2,
                 ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, 1'b1);
    end

    $display("[TB] early wlast");
    for (int i = 0; i < 4; i++) begin
      wdata_q[i] = $urandom;
      wstrb_q[i] = 4'hF;
    end
    write_burst(4'h6, 32'h400, 8'd3, 3'd2, 2'b01, 1'b1, 1'b1);

    $display("[TB] reset during read burst");
    s_axi_arid = 4'hE; s_axi_araddr = 32'h800; s_axi_arlen = 8'd15;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 200) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge aclk); n++; end
    s_axi_rready = 1'b1;
    @(negedge aclk);
    s_axi_rready = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge aclk); n++; end
    check_output("rst_setup_rvalid", {63'd0, s_axi_rvalid}, 64'd1);
    #2 aresetn = 1'b0;
    #1;
    check_output("midrst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    check_output("midrst_arready", {63'd0, s_axi_arready}, 64'd0);
    check_output("midrst_awready", {63'd0, s_axi_awready}, 64'd0);
    check_output("midrst_rdata",   {32'd0, s_axi_rdata},   64'd0);
    check_output("midrst_rid",     {60'd0, s_axi_rid},     64'd0);
    check_output("midrst_rlast",   {63'd0, s_axi_rlast},   64'd0);
    check_output("midrst_bid",     {60'd0, s_axi_bid},     64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_output("rel_arready", {63'd0, s_axi_arready}, 64'd1);
    check_output("rel_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    read_burst(4'h2, 32'h800, 8'd3, 3'd2, 2'b01, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
